// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering the cpu's load/store valid/ready
// requests after a configurable access latency.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE, low during reset)
//   req_we             1 = store, 0 = load
//   req_addr           byte address; word index is addr[31:2]
//   req_wdata, req_be  store data and per-byte enables (bit i -> byte i)
//   resp_valid/ready   response handshake; response held until accepted
//   resp_rdata         load data (0 for stores and errored requests)
//   resp_err           misaligned or out-of-range request
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int unsigned NBYTES   = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
    localparam bit          FAST     = (LATENCY == 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Elaboration-time parameter legality checks
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY=%0d outside 1..15", LATENCY);
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("data_mem_responder: DATA_WIDTH=%0d not a multiple of 8", DATA_WIDTH);
    end

    logic [1:0]            state, state_nxt;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  commit;

    logic                  lat_we;
    logic [31:0]           lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [NBYTES-1:0]     lat_be;

    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [NBYTES-1:0]     acc_be;
    logic [29:0]           acc_idx;
    logic                  acc_err;
    logic [IDX_W-1:0]      mem_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    assign req_ready = (state == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // The single-cycle build commits straight from the request inputs;
    // otherwise the access uses the copy latched at acceptance.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_be    = lat_be;
        if (state == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
    end

    assign acc_idx = acc_addr[31:2];
    assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_idx} >= 32'(MEM_WORDS));
    assign mem_idx = acc_idx[IDX_W-1:0];
    assign commit  = !reset && ((FAST && state == S_IDLE && req_valid) ||
                                (state == S_WAIT && cnt == 4'd1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid)     state_nxt = FAST ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd1)   state_nxt = S_RESP;
            S_RESP:  if (resp_ready)    state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Request capture at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // Latency counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_we || acc_err) ? {DATA_WIDTH{1'b0}} : mem[mem_idx];
            end else if (state == S_RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= {DATA_WIDTH{1'b0}};
                resp_err   <= 1'b0;
            end
        end
    end

    // Byte-enabled store; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (acc_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: a LATENCY=3 and a LATENCY=1 instance
// are driven in turn and compared against a word-level memory model.
module tb_data_mem_responder;

    logic        clk;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: key = dut*4096 + word index; absent key = never fully written
    logic [31:0] model [int];

    data_mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response exchange; hold = cycles of response backpressure
    task automatic transact(input int d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int hold, output int acc_cyc);
        int          lat;
        int          edges;
        int          idx;
        int          key;
        bit          exp_err;
        bit          known;
        logic [31:0] exp_rd;
        logic [31:0] w;

        lat     = (d == 0) ? 3 : 1;
        idx     = int'(addr >> 2);
        exp_err = (addr % 4 != 0) || (idx >= 1024);
        exp_rd  = 32'h0;
        known   = 1'b1;
        key     = d * 4096 + idx;

        if (!exp_err && we) begin
            if (model.exists(key) || be == 4'hF) begin
                w = model.exists(key) ? model[key] : 32'h0;
                for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
                model[key] = w;
            end
        end else if (!exp_err) begin
            known = model.exists(key);
            if (known) exp_rd = model[key];
        end

        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        tick();
        acc_cyc = cyc;
        edges   = 1;
        while (!resp_valid[d] && edges < 40) begin
            check("req_ready_busy", 32'(req_ready[d]), 32'd0);
            // Junk on the request bus while busy must be ignored
            req_valid[d] = 1'($urandom);
            req_we[d]    = 1'($urandom);
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
            req_be[d]    = 4'($urandom);
            tick();
            edges++;
        end
        req_valid[d] = 1'b0;
        check("latency", 32'(edges), 32'(lat));

        repeat (hold) begin
            check("hold_valid", 32'(resp_valid[d]), 32'd1);
            if (known) check("hold_rdata", resp_rdata[d], exp_rd);
            check("hold_ready", 32'(req_ready[d]), 32'd0);
            tick();
        end
        check("resp_valid", 32'(resp_valid[d]), 32'd1);
        check("resp_err", 32'(resp_err[d]), 32'(exp_err));
        if (known) check("resp_rdata", resp_rdata[d], exp_rd);

        resp_ready[d] = 1'b1;
        tick();
        resp_ready[d] = 1'b0;
        check("post_valid", 32'(resp_valid[d]), 32'd0);
        check("post_rdata", resp_rdata[d], 32'h0);
        check("post_ready", 32'(req_ready[d]), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16)  return 32'(r * 4);
        if (r == 16) return 32'h0000_0FFC;
        if (r == 17) return 32'h0000_1000;
        if (r == 18) return $urandom | 32'h1;
        return 32'hFFFF_FFF0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;

        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_be[d] = 4'h0;
            resp_ready[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", resp_rdata[d], 32'h0);
            check("rst_err", 32'(resp_err[d]), 32'd0);
        end
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready[0]), 32'd1);

        // Directed scenarios, LATENCY=3
        transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, acc);
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);
        transact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1, acc);
        transact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, acc);
        check("byte_merge_model", model[16'h0004], 32'hDE22BE44);
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, acc);
        transact(0, 1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, acc);
        transact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, acc);
        transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, acc);

        // Reset during WAIT abandons the store
        transact(0, 1'b1, 32'h20, 32'h0, 4'hF, 0, acc);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h55AA55AA; req_be[0] = 4'hF;
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("abort_wait_valid", 32'(resp_valid[0]), 32'd0);
        reset[0] = 1'b1;
        #1;
        check("abort_rst_ready", 32'(req_ready[0]), 32'd0);
        tick();
        reset[0] = 1'b0;
        #1;
        repeat (5) begin
            check("abort_no_resp", 32'(resp_valid[0]), 32'd0);
            check("abort_idle", 32'(req_ready[0]), 32'd1);
            tick();
        end
        transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, acc);

        // Reset during RESP drops the response
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        check("drop_resp_pre", 32'(resp_valid[0]), 32'd1);
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        #1;
        check("drop_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("drop_resp_rdata", resp_rdata[0], 32'h0);
        check("drop_resp_ready", 32'(req_ready[0]), 32'd1);

        // Randomized traffic, LATENCY=3
        for (int i = 0; i < 16; i++) transact(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, acc);
        transact(0, 1'b1, 32'hFFC, $urandom, 4'hF, 0, acc);
        for (int i = 0; i < 40; i++)
            transact(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 3)), acc);

        // LATENCY=1: fast path and back-to-back spacing
        for (int i = 0; i < 8; i++) transact(1, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, acc);
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            transact(1, 1'($urandom), 32'($urandom_range(0, 7) * 4), $urandom, 4'($urandom), 0, acc);
            if (i > 0) check("b2b_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
